ddr_app_responder: RTL and testbench

DDR_APP_RESPONDER -- requirements
Module: ddr_app_responder

---
 rtl/ddr_app_pkg.sv | 17 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/ddr_app_responder.sv | 206 ++++++++++++++++++++
 tb/tb_ddr_app_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_app_pkg.sv
// Shared types and constants for the DDR application-interface responder model.
package ddr_app_pkg;

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        CMD_WRITE = 3'b000,
        CMD_READ  = 3'b001
    } app_cmd_t;

    typedef enum logic [1:0] {
        ST_CALIB,
        ST_IDLE,
        ST_WAIT_WDATA
    } exec_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read port; pushes when full and pops when empty are ignored.
module sync_fifo
    import ddr_app_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = storage[rd_ptr];

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage arrays carry no reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ddr_app_responder.sv
// Behavioural responder for a DDR controller app interface: calibration delay, command and
// write-data queues, byte-masked burst memory and a fixed-latency read return path.
module ddr_app_responder
    import ddr_app_pkg::*;
#(
    parameter int ADDR_WIDTH     = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int MASK_WIDTH     = 16,
    parameter int DEPTH_LOG2     = 10,
    parameter int CALIB_CYCLES   = 100,
    parameter int READ_LATENCY   = 8,
    parameter int STALL_PERIOD   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     app_addr,
    input  logic [2:0]                app_cmd,
    input  logic                      app_en,
    input  logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    input  logic [MASK_WIDTH-1:0]     app_wdf_mask,
    input  logic                      app_wdf_wren,
    input  logic                      app_wdf_end,
    output logic                      app_rdy,
    output logic                      app_wdf_rdy,
    output logic [APP_DATA_WIDTH-1:0] app_rd_data,
    output logic                      app_rd_data_valid,
    output logic                      app_rd_data_end,
    output logic                      init_calib_complete,
    output logic                      proto_error
);

    localparam int CMD_W = 3 + ADDR_WIDTH;
    localparam int DAT_W = APP_DATA_WIDTH + MASK_WIDTH;
    localparam int CAL_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam int STL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CALIB_CYCLES - 1);
    localparam logic [STL_W-1:0] STL_LAST = STL_W'(STALL_PERIOD - 1);

    exec_state_t state, next_state;
    logic [CAL_W-1:0] cal_cnt;
    logic [STL_W-1:0] stl_cnt;
    logic             calib_done;
    logic             stall;

    logic             cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [CMD_W-1:0] cmd_rdata;
    logic             data_push, data_pop, data_full, data_empty;
    logic [DAT_W-1:0] data_rdata;

    logic [2:0]                head_cmd;
    logic [ADDR_WIDTH-1:0]     head_addr;
    logic [DEPTH_LOG2-1:0]     mem_idx;
    logic [APP_DATA_WIDTH-1:0] wr_word;
    logic [MASK_WIDTH-1:0]     wr_mask;
    logic                      unused_addr;

    logic mem_we, rd_issue, bad_cmd;

    logic [APP_DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [READ_LATENCY-1:0]   pipe_valid;
    logic [APP_DATA_WIDTH-1:0] pipe_data [READ_LATENCY];

    assign calib_done          = (state != ST_CALIB);
    assign init_calib_complete = calib_done;
    assign stall               = (STALL_PERIOD != 0) && (stl_cnt == STL_LAST);
    assign app_rdy             = calib_done && !cmd_full && !stall;
    assign app_wdf_rdy         = calib_done && !data_full;
    assign app_rd_data_end     = app_rd_data_valid;

    assign cmd_push  = app_en && app_rdy;
    assign data_push = app_wdf_wren && app_wdf_rdy;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_push),
        .wdata ({app_cmd, app_addr}),
        .pop   (cmd_pop),
        .rdata (cmd_rdata),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    sync_fifo #(.WIDTH(DAT_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (data_push),
        .wdata ({app_wdf_data, app_wdf_mask}),
        .pop   (data_pop),
        .rdata (data_rdata),
        .full  (data_full),
        .empty (data_empty)
    );

    assign head_cmd  = cmd_rdata[CMD_W-1 -: 3];
    assign head_addr = cmd_rdata[ADDR_WIDTH-1:0];
    assign mem_idx   = head_addr[3 +: DEPTH_LOG2];
    assign wr_word   = data_rdata[DAT_W-1 -: APP_DATA_WIDTH];
    assign wr_mask   = data_rdata[MASK_WIDTH-1:0];
    // Burst offset and aliasing upper address bits are intentionally dropped.
    assign unused_addr = ^head_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_CALIB;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            ST_CALIB:      if (cal_cnt == CAL_LAST) next_state = ST_IDLE;
            ST_IDLE:       if (!cmd_empty && head_cmd == CMD_WRITE && data_empty)
                               next_state = ST_WAIT_WDATA;
            ST_WAIT_WDATA: if (!data_empty) next_state = ST_IDLE;
            default:       next_state = ST_CALIB;
        endcase
    end

    // A write waiting for data stays at the command FIFO head, so it still occupies a slot.
    always_comb begin
        cmd_pop  = 1'b0;
        data_pop = 1'b0;
        mem_we   = 1'b0;
        rd_issue = 1'b0;
        bad_cmd  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cmd_empty) begin
                    case (head_cmd)
                        CMD_WRITE: begin
                            if (!data_empty) begin
                                cmd_pop  = 1'b1;
                                data_pop = 1'b1;
                                mem_we   = 1'b1;
                            end
                        end
                        CMD_READ: begin
                            cmd_pop  = 1'b1;
                            rd_issue = 1'b1;
                        end
                        default: begin
                            cmd_pop = 1'b1;
                            bad_cmd = 1'b1;
                        end
                    endcase
                end
            end
            ST_WAIT_WDATA: begin
                if (!data_empty) begin
                    cmd_pop  = 1'b1;
                    data_pop = 1'b1;
                    mem_we   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_cnt <= '0;
            stl_cnt <= '0;
        end else begin
            if (state == ST_CALIB && cal_cnt != CAL_LAST) cal_cnt <= cal_cnt + 1'b1;
            if (calib_done && STALL_PERIOD != 0)
                stl_cnt <= (stl_cnt == STL_LAST) ? '0 : stl_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_error <= 1'b0;
        end else if (bad_cmd || (data_push && !app_wdf_end) ||
                     (!calib_done && (app_en || app_wdf_wren))) begin
            proto_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (!wr_mask[b]) mem[mem_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
            end
        end
    end

    // Data stages need no reset: only the valid bits decide what reaches the output.
    always_ff @(posedge clk) begin
        if (rd_issue) pipe_data[0] <= mem[mem_idx];
        for (int i = 1; i < READ_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid        <= '0;
            app_rd_data_valid <= 1'b0;
            app_rd_data       <= '0;
        end else begin
            pipe_valid        <= {pipe_valid[READ_LATENCY-2:0], rd_issue};
            app_rd_data_valid <= pipe_valid[READ_LATENCY-1];
            if (pipe_valid[READ_LATENCY-1]) app_rd_data <= pipe_data[READ_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_ddr_app_responder.sv
// Directed self-checking bench for ddr_app_responder with a 4-cycle app_rdy stall pattern.
module tb_ddr_app_responder;
    import ddr_app_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_rdy;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;
    logic         proto_error;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int valid_seen = 0;
    bit collect  = 1'b0;
    logic [127:0] rd_q [$];

    ddr_app_responder #(
        .ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .MASK_WIDTH(16), .DEPTH_LOG2(10),
        .CALIB_CYCLES(100), .READ_LATENCY(8), .STALL_PERIOD(4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .init_calib_complete (init_calib_complete),
        .proto_error         (proto_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (app_rd_data_valid) begin
            valid_seen <= valid_seen + 1;
            if (collect) rd_q.push_back(app_rd_data);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [27:0] a);
        int n = 0;
        app_cmd = c;
        app_addr = a;
        app_en = 1'b1;
        while (!app_rdy && n < 50) begin
            step();
            n++;
        end
        check("cmd_rdy", app_rdy, 1'b1);
        step();
        app_en = 1'b0;
    endtask

    task automatic send_data(input logic [127:0] d, input logic [15:0] m, input logic e);
        int n = 0;
        app_wdf_data = d;
        app_wdf_mask = m;
        app_wdf_end  = e;
        app_wdf_wren = 1'b1;
        while (!app_wdf_rdy && n < 50) begin
            step();
            n++;
        end
        check("wdf_rdy", app_wdf_rdy, 1'b1);
        step();
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
    endtask

    task automatic write_word(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
        send_cmd(CMD_WRITE, a);
        send_data(d, m, 1'b1);
        idle(3);
    endtask

    task automatic read_check(input string tag, input logic [27:0] a, input logic [127:0] exp);
        int t0;
        int n = 0;
        send_cmd(CMD_READ, a);
        t0 = cyc;
        while (!app_rd_data_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_valid"}, app_rd_data_valid, 1'b1);
        check({tag, "_lat"}, cyc - t0, 9);
        check({tag, "_end"}, app_rd_data_end, 1'b1);
        check({tag, "_data"}, app_rd_data, exp);
        step();
        check({tag, "_drop"}, app_rd_data_valid, 1'b0);
        check({tag, "_hold"}, app_rd_data, exp);
    endtask

    task automatic wait_calib();
        int n = 0;
        while (!init_calib_complete && n < 150) begin
            step();
            n++;
        end
        check("calib_done", init_calib_complete, 1'b1);
    endtask

    initial begin
        logic [127:0] pat;
        logic [127:0] nw;
        logic [7:0]   bv;
        bit   rdy_hist [64];
        int   k;
        int   f;
        int   idx;
        int   v0;

        rst_n = 1'b0;
        app_addr = '0; app_cmd = '0; app_en = 1'b0;
        app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        pat = 128'h0f0e0d0c0b0a09080706050403020100;
        nw  = 128'h1122334455667788_99aabbccddeeff00;

        // Reset state and calibration timing
        idle(3);
        check("rst_calib", init_calib_complete, 1'b0);
        check("rst_rdy", app_rdy, 1'b0);
        check("rst_wdf_rdy", app_wdf_rdy, 1'b0);
        check("rst_valid", app_rd_data_valid, 1'b0);
        check("rst_rd_data", app_rd_data, 128'h0);
        check("rst_proto", proto_error, 1'b0);
        rst_n = 1'b1;
        idle(99);
        check("calib_99", init_calib_complete, 1'b0);
        check("rdy_99", app_rdy, 1'b0);
        step();
        check("calib_100", init_calib_complete, 1'b1);
        check("rdy_100", app_rdy, 1'b1);
        check("wdf_rdy_100", app_wdf_rdy, 1'b1);

        // Full write then read, with offset and alias address variants
        write_word(28'h8, pat, 16'h0000);
        read_check("rd_0x8", 28'h8, pat);
        idle(2);
        read_check("rd_offset", 28'hC, pat);
        idle(2);
        read_check("rd_alias", 28'h2008, pat);

        // Late write data with byte mask over an all-ones word
        write_word(28'h10, {128{1'b1}}, 16'h0000);
        send_cmd(CMD_WRITE, 28'h10);
        idle(3);
        check("wait_wdata_state", dut.state, ST_WAIT_WDATA);
        send_data(nw, 16'h00FF, 1'b1);
        idle(3);
        check("state_idle_after", dut.state, ST_IDLE);
        read_check("rd_mask", 28'h10, {nw[127:64], 64'hFFFF_FFFF_FFFF_FFFF});

        // Command FIFO fills while the head write waits for data
        idle(2);
        for (int i = 0; i < 4; i++) send_cmd(CMD_WRITE, 28'(28'h40 + 8 * i));
        check("full_rdy_low", app_rdy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("full_hold_rdy", app_rdy, 1'b0);
        end
        check("full_wait_state", dut.state, ST_WAIT_WDATA);
        for (int i = 0; i < 4; i++) begin
            bv = 8'(8'h40 + i);
            send_data({16{bv}}, 16'h0000, 1'b1);
        end
        bv = 8'h44;
        write_word(28'h60, {16{bv}}, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            bv = 8'(8'h40 + i);
            idle(2);
            read_check("rd_queued", 28'(28'h40 + 8 * i), {16{bv}});
        end

        // Continuous reads against the stall pattern
        for (int i = 0; i < 8; i++) begin
            bv = 8'(8'hC0 + i);
            write_word(28'(8 * i), {16{bv}}, 16'h0000);
        end
        idle(4);
        rd_q.delete();
        collect = 1'b1;
        app_cmd = CMD_READ;
        app_addr = 28'h0;
        app_en = 1'b1;
        idx = 0;
        k = 0;
        while (idx < 8 && k < 40) begin
            rdy_hist[k] = app_rdy;
            step();
            if (rdy_hist[k]) begin
                idx++;
                app_addr = 28'(8 * idx);
            end
            k++;
        end
        app_en = 1'b0;
        check("stream_accepts", idx, 8);
        f = 0;
        while (f < k && rdy_hist[f]) f++;
        check("stall_first_low", (f < 4), 1'b1);
        for (int j = f; j < k; j++) check("stall_pattern", rdy_hist[j], ((j - f) % 4) != 0);
        for (int n = 0; n < 30 && rd_q.size() < 8; n++) step();
        check("stream_count", rd_q.size(), 8);
        for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
            bv = 8'(8'hC0 + i);
            check("stream_data", rd_q[i], {16{bv}});
        end
        collect = 1'b0;

        // Unknown command is discarded and flags a sticky error
        check("proto_clean", proto_error, 1'b0);
        send_cmd(3'b010, 28'h0);
        idle(3);
        check("proto_badcmd", proto_error, 1'b1);
        check("badcmd_popped", dut.state, ST_IDLE);
        idle(20);
        check("proto_sticky", proto_error, 1'b1);

        // Reset with a read in flight, then traffic during calibration
        send_cmd(CMD_READ, 28'h8);
        idle(3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", app_rd_data_valid, 1'b0);
        check("mid_rst_data", app_rd_data, 128'h0);
        check("mid_rst_proto", proto_error, 1'b0);
        check("mid_rst_rdy", app_rdy, 1'b0);
        check("mid_rst_calib", init_calib_complete, 1'b0);
        idle(3);
        v0 = valid_seen;
        rst_n = 1'b1;
        idle(15);
        app_cmd = CMD_READ; app_addr = 28'h8; app_en = 1'b1;
        app_wdf_data = {8{16'hDEAD}}; app_wdf_mask = '0; app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
        step();
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        step();
        check("proto_precal", proto_error, 1'b1);
        wait_calib();
        idle(12);
        check("no_stale_valid", valid_seen - v0, 0);
        send_cmd(CMD_WRITE, 28'h78);
        idle(3);
        check("no_stale_wdata", dut.state, ST_WAIT_WDATA);
        send_data(pat, 16'h0000, 1'b1);
        idle(3);
        read_check("rd_after_rst", 28'h78, pat);

        // Write data without end is flagged but still committed
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        wait_calib();
        check("proto_cleared", proto_error, 1'b0);
        send_data(nw, 16'h0000, 1'b0);
        idle(2);
        check("proto_noend", proto_error, 1'b1);
        send_cmd(CMD_WRITE, 28'h70);
        idle(4);
        read_check("rd_noend", 28'h70, nw);
        check("proto_noend_sticky", proto_error, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
